firewall_st_filter: RTL
=======================

// Module: firewall_st_filter
// PURPOSE
//   Parametrised store-and-forward EtherType filter between the MAC RX Avalon-ST source and the MAC TX sink.
//   Buffers each frame whole in a frame RAM. Forwards it only if it is error-free, at least 14 bytes long,
//   and its EtherType matches no enabled block rule. Otherwise the frame is dropped silently.
//   Adds SOP/EOP framing, a CH_W-bit channel (ingress port tag) and NUM_RULES runtime rules.
// PARAMETERS
//   CH_W        1     width of Avalon-ST channel field (2**CH_W ports share the filter)
//   FIFO_AW     11    frame RAM address width; depth = 2**FIFO_AW bytes
//   NUM_RULES   4     number of EtherType block rules
//   RULE_IW     2     rule index width, >= clog2(NUM_RULES)
// PORTS
//   Clk            in   1        system clock, 125 MHz
//   Rst_n          in   1        async active-low reset
//   S_valid        in   1        ingress byte valid
//   S_data         in   8        ingress byte
//   S_channel      in   CH_W     ingress port tag, sampled on SOP byte
//   S_error        in   1        byte carries GMII RX_ER
//   S_sop          in   1        first byte of frame
//   S_eop          in   1        last byte of frame
//   S_ready        out  1        held 1 out of reset (MAC cannot be stalled)
//   M_valid        out  1        egress byte valid
//   M_data         out  8        egress byte
//   M_channel      out  CH_W     channel of current frame
//   M_error        out  1        always 0 (errored frames never forwarded)
//   M_sop          out  1        first byte of frame
//   M_eop          out  1        last byte of frame
//   M_ready        in   1        downstream accept
//   Cfg_wr         in   1        rule write strobe
//   Cfg_idx        in   RULE_IW  rule index
//   Cfg_en         in   1        rule enable
//   Cfg_etype      in   16       EtherType to block
//   Pass_cnt       out  32       frames forwarded
//   Drop_cnt       out  32       frames dropped
// BEHAVIOUR
//   Reset values:
//     - all M_* = 0; S_ready = 0 during reset, 1 from first clock after release; counters = 0.
//     - rules: en = 0, etype = 0. All pointers = 0; write FSM = W_IDLE.
//     - Reset mid-frame discards every buffered and partial frame.
//   Byte transfer: a byte transfers when valid & ready. Ingress S_ready stays 1; M_* hold stable while M_valid & !M_ready.
//   Write FSM:
//     - W_IDLE: on SOP, go W_RECV with wr_ptr = commit_ptr. Non-SOP bytes are ignored.
//     - W_RECV: write {eop, channel, data} at wr_ptr++. Bytes 12/13 (0-based) latch EtherType hi/lo.
//         - Error or full RAM -> W_DROP.
//         - EOP -> evaluate verdict.
//         - SOP without prior EOP -> abort old frame (drop), restart as new frame same cycle.
//     - W_DROP: discard bytes until EOP (or new SOP, treated as above); rewind wr_ptr = commit_ptr; return to W_IDLE.
//   Verdict at EOP (cycle N):
//     - Drop if: error seen, length < 14, or any enabled rule etype == frame EtherType.
//     - Pass: commit_ptr <= wr_ptr at end of N, Pass_cnt++.
//     - Drop: rewind wr_ptr, Drop_cnt++.
//     - EOP byte with error also counts as drop.
//   Full: wr_ptr+1 == rd_ptr (one slot reserved). Overflow drops only the current frame; committed frames are untouched.
//   Read side:
//     - M_valid = 1 while rd_ptr != commit_ptr (registered RAM read, output register).
//     - Empty FIFO latency: EOP accepted cycle N -> M_valid & M_sop in cycle N+2.
//     - Back-to-back frames stream with no idle cycle if M_ready = 1.
//   Rule config:
//     - Cfg_wr updates rule Cfg_idx at the clock edge; takes effect for verdicts from the next cycle.
//     - A write and a verdict in the same cycle use the old rule value.
//     - Cfg_idx >= NUM_RULES is ignored.
//   Pointers: FIFO_AW bits, natural wrap-around modulo depth.
// CONFIGURATION
//   FW_STATS_EN defined: Pass_cnt/Drop_cnt are 32-bit saturating counters (stick at 0xFFFF_FFFF).
//   FW_STATS_EN undefined: counters not built; Pass_cnt/Drop_cnt tied to 0.
// STRUCTURE
//   fw_pkg:
//     - ETYPE_HI_OFS = 12, ETYPE_LO_OFS = 13, MIN_FRAME_LEN = 14.
//     - Write-FSM enum {W_IDLE, W_RECV, W_DROP}.
//     - Typedef for the RAM word {eop, channel, data}.
//   Sub-module fw_frame_ram: simple dual-port RAM, 1 write and 1 registered read port, depth 2**FIFO_AW,
//   width 9+CH_W.
// TESTING
//   1. 64B frame, EtherType 0x0800, no rules -> identical 64B egress, sop/eop correct, channel kept,
//      Pass_cnt = 1, M_sop at EOP+2.
//   2. Rule0 = 0x86DD enabled; send IPv6 frame then IPv4 frame -> only IPv4 frame egresses, Drop_cnt = 1, Pass_cnt = 1.
//   3. S_error on byte 30 of 100B frame -> frame absent at egress, Drop_cnt = 1; next good frame passes intact.
//   4. 10B runt frame, and a frame with SOP but no EOP followed by a new SOP -> both dropped (Drop_cnt = 2);
//      the new frame passes.
//   5. FIFO_AW = 7, M_ready = 0, send 100B then 100B -> first passes, second dropped on full.
//      Release M_ready -> exactly the first frame drains.
//   6. Assert Rst_n low mid-egress -> M_valid = 0 immediately, FIFO empty; frame after reset passes.
//      With FW_STATS_EN undefined, counters read 0.

Source files
------------

// File: rtl/fw_pkg.sv
// Shared constants and types for the store-and-forward EtherType filter.
package fw_pkg;

  localparam int unsigned ETYPE_HI_OFS  = 12;
  localparam int unsigned ETYPE_LO_OFS  = 13;
  localparam int unsigned MIN_FRAME_LEN = 14;
  // Byte-position counter width; it saturates at MIN_FRAME_LEN.
  localparam int unsigned LEN_CNT_W     = 4;

  typedef enum logic [1:0] {
    W_IDLE,
    W_RECV,
    W_DROP
  } wr_state_e;

endpackage

// File: rtl/fw_frame_ram.sv
// Simple dual-port frame RAM: one write port, one read port with a registered output.
module fw_frame_ram #(
  parameter int unsigned AW = 11,
  parameter int unsigned W  = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/firewall_st_filter.sv
// Store-and-forward EtherType filter: forwards only clean, long-enough, unblocked frames.
// Define FW_STATS_EN to build the saturating pass/drop counters (otherwise they read 0).
module firewall_st_filter
  import fw_pkg::*;
#(
  parameter int unsigned CH_W      = 1,
  parameter int unsigned FIFO_AW   = 11,
  parameter int unsigned NUM_RULES = 4,
  parameter int unsigned RULE_IW   = 2
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               S_valid,
  input  logic [7:0]         S_data,
  input  logic [CH_W-1:0]    S_channel,
  input  logic               S_error,
  input  logic               S_sop,
  input  logic               S_eop,
  output logic               S_ready,
  output logic               M_valid,
  output logic [7:0]         M_data,
  output logic [CH_W-1:0]    M_channel,
  output logic               M_error,
  output logic               M_sop,
  output logic               M_eop,
  input  logic               M_ready,
  input  logic               Cfg_wr,
  input  logic [RULE_IW-1:0] Cfg_idx,
  input  logic               Cfg_en,
  input  logic [15:0]        Cfg_etype,
  output logic [31:0]        Pass_cnt,
  output logic [31:0]        Drop_cnt
);

  typedef struct packed {
    logic            eop;
    logic [CH_W-1:0] channel;
    logic [7:0]      data;
  } ram_word_t;

  localparam int unsigned RamW = $bits(ram_word_t);

  wr_state_e              wr_st_q, wr_st_d;
  logic [FIFO_AW-1:0]     wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEN_CNT_W-1:0]   len_q, len_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [7:0]             etype_hi_q, etype_hi_d, etype_lo_q, etype_lo_d;
  logic                   rule_en_q [NUM_RULES];
  logic                   rule_en_d [NUM_RULES];
  logic [15:0]            rule_etype_q [NUM_RULES];
  logic [15:0]            rule_etype_d [NUM_RULES];
  logic                   s_ready_q, m_valid_q, m_valid_d, out_sop_q, out_sop_d;

  logic                   in_fire, start, full, len_ok, blocked, ram_we, rd_en;
  logic [FIFO_AW-1:0]     base_ptr;
  logic [LEN_CNT_W-1:0]   idx;
  logic [CH_W-1:0]        cur_ch;
  logic [15:0]            frame_etype;
  logic                   pass_inc;
  logic [1:0]             drop_inc;
  ram_word_t              ram_wdata, rd_word;

  // A SOP byte always opens a new frame at the last committed position.
  assign in_fire     = S_valid & s_ready_q;
  assign start       = S_sop;
  assign base_ptr    = start ? commit_ptr_q : wr_ptr_q;
  assign idx         = start ? '0 : len_q;
  assign cur_ch      = start ? S_channel : ch_q;
  assign full        = (base_ptr + FIFO_AW'(1)) == rd_ptr_q;
  assign len_ok      = idx >= LEN_CNT_W'(MIN_FRAME_LEN - 1);
  assign frame_etype = {etype_hi_q, (idx == LEN_CNT_W'(ETYPE_LO_OFS)) ? S_data : etype_lo_q};
  assign ram_wdata   = '{eop: S_eop, channel: cur_ch, data: S_data};

  always_comb begin
    blocked = 1'b0;
    for (int unsigned i = 0; i < NUM_RULES; i++) begin
      if (rule_en_q[i] && (rule_etype_q[i] == frame_etype)) blocked = 1'b1;
    end
  end

  always_comb begin
    wr_st_d      = wr_st_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    len_d        = len_q;
    ch_d         = ch_q;
    etype_hi_d   = etype_hi_q;
    etype_lo_d   = etype_lo_q;
    ram_we       = 1'b0;
    pass_inc     = 1'b0;
    drop_inc     = 2'd0;
    if (in_fire) begin
      if (start || (wr_st_q == W_RECV)) begin
        if (start && (wr_st_q == W_RECV)) drop_inc = drop_inc + 2'd1;
        ch_d  = cur_ch;
        len_d = (idx == LEN_CNT_W'(MIN_FRAME_LEN)) ? idx : idx + LEN_CNT_W'(1);
        if (idx == LEN_CNT_W'(ETYPE_HI_OFS)) etype_hi_d = S_data;
        if (idx == LEN_CNT_W'(ETYPE_LO_OFS)) etype_lo_d = S_data;
        if (S_error || full) begin
          drop_inc = drop_inc + 2'd1;
          wr_ptr_d = commit_ptr_q;
          wr_st_d  = S_eop ? W_IDLE : W_DROP;
        end else begin
          ram_we   = 1'b1;
          wr_ptr_d = base_ptr + FIFO_AW'(1);
          wr_st_d  = S_eop ? W_IDLE : W_RECV;
          if (S_eop) begin
            if (len_ok && !blocked) begin
              commit_ptr_d = base_ptr + FIFO_AW'(1);
              pass_inc     = 1'b1;
            end else begin
              drop_inc = drop_inc + 2'd1;
              wr_ptr_d = commit_ptr_q;
            end
          end
        end
      end else if ((wr_st_q == W_DROP) && S_eop) begin
        wr_st_d  = W_IDLE;
        wr_ptr_d = commit_ptr_q;
      end
    end
  end

  // Rule writes land at the edge, so a verdict in the same cycle sees the old value.
  always_comb begin
    rule_en_d    = rule_en_q;
    rule_etype_d = rule_etype_q;
    for (int unsigned i = 0; i < NUM_RULES; i++) begin
      if (Cfg_wr && (Cfg_idx == RULE_IW'(i))) begin
        rule_en_d[i]    = Cfg_en;
        rule_etype_d[i] = Cfg_etype;
      end
    end
  end

  // The RAM read register doubles as the egress output register.
  always_comb begin
    rd_en     = (rd_ptr_q != commit_ptr_q) && (!m_valid_q || M_ready);
    rd_ptr_d  = rd_en ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    m_valid_d = rd_en ? 1'b1 : (M_ready ? 1'b0 : m_valid_q);
    out_sop_d = (m_valid_q && M_ready) ? rd_word.eop : out_sop_q;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_st_q      <= W_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      ch_q         <= '0;
      etype_hi_q   <= '0;
      etype_lo_q   <= '0;
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      out_sop_q    <= 1'b1;
      for (int unsigned i = 0; i < NUM_RULES; i++) begin
        rule_en_q[i]    <= 1'b0;
        rule_etype_q[i] <= '0;
      end
    end else begin
      wr_st_q      <= wr_st_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      len_q        <= len_d;
      ch_q         <= ch_d;
      etype_hi_q   <= etype_hi_d;
      etype_lo_q   <= etype_lo_d;
      s_ready_q    <= 1'b1;
      m_valid_q    <= m_valid_d;
      out_sop_q    <= out_sop_d;
      rule_en_q    <= rule_en_d;
      rule_etype_q <= rule_etype_d;
    end
  end

  fw_frame_ram #(
    .AW (FIFO_AW),
    .W  (RamW)
  ) u_ram (
    .clk_i   (Clk),
    .we_i    (ram_we),
    .waddr_i (base_ptr),
    .wdata_i (ram_wdata),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_word)
  );

  assign S_ready   = s_ready_q;
  assign M_valid   = m_valid_q;
  assign M_data    = m_valid_q ? rd_word.data : '0;
  assign M_channel = m_valid_q ? rd_word.channel : '0;
  assign M_eop     = m_valid_q & rd_word.eop;
  assign M_sop     = m_valid_q & out_sop_q;
  assign M_error   = 1'b0;

`ifdef FW_STATS_EN
  logic [31:0] pass_cnt_q, pass_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [32:0] drop_sum;

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    if (pass_inc && (pass_cnt_q != '1)) pass_cnt_d = pass_cnt_q + 32'd1;
    drop_sum   = {1'b0, drop_cnt_q} + 33'(drop_inc);
    drop_cnt_d = drop_sum[32] ? '1 : drop_sum[31:0];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign Pass_cnt = pass_cnt_q;
  assign Drop_cnt = drop_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = ^{pass_inc, drop_inc};
  assign Pass_cnt     = '0;
  assign Drop_cnt     = '0;
`endif

endmodule
